// File: rtl/branch_pkg.sv
// Shared types for the branch redirect controller: prediction queue entry and FSM states.
package branch_pkg;

    localparam int unsigned PKG_ADDR_W     = 64;
    localparam int unsigned PKG_PRED_DEPTH = 8;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] pc;
        logic                  taken;
        logic [PKG_ADDR_W-1:0] target;
    } pred_entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } redirect_state_e;

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of fetch-time predictions; pointers carry an extra wrap bit for full/empty.
module pred_fifo
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = PKG_PRED_DEPTH
) (
    input  logic        clk_in,
    input  logic        rst_N_in,
    input  logic        push_in,
    input  logic        pop_in,
    input  logic        clear_in,
    input  pred_entry_t din_in,
    output pred_entry_t head_out,
    output logic        full_out,
    output logic        empty_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    pred_entry_t    mem_q [DEPTH];

    // Pointer update; clear wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_in && !full_out) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            if (pop_in && !empty_out) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk_in) begin
        if (push_in && !full_out && !clear_in) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_in;
    end

    assign empty_out = (wr_ptr_q == rd_ptr_q);
    assign full_out  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_out  = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/bru_redirect_ctrl.sv
// Branch resolution receiver: compares BRU outcomes against queued predictions,
// pulses a flush on mispredict and holds a fetch redirect until accepted.
// Optional BRU_PERF_CNT_EN adds resolution / misprediction counters.
module bru_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned PRED_DEPTH = PKG_PRED_DEPTH,
    parameter int unsigned ADDR_W     = PKG_ADDR_W
) (
    input  logic              clk_in,
    input  logic              rst_N_in,
    input  logic              pred_valid_in,
    output logic              pred_ready_out,
    input  logic [ADDR_W-1:0] pred_pc_in,
    input  logic              pred_taken_in,
    input  logic [ADDR_W-1:0] pred_target_in,
    input  logic              res_valid_in,
    input  logic              res_taken_in,
    input  logic [ADDR_W-1:0] res_target_in,
    output logic              flush_out,
    output logic              redirect_valid_out,
    input  logic              redirect_ready_in,
    output logic [ADDR_W-1:0] redirect_pc_out,
    output logic              orphan_err_out,
    output logic [31:0]       res_count_out,
    output logic [31:0]       mispred_count_out
);

    redirect_state_e   state_q, state_d;
    logic              flush_q, flush_d;
    logic              redir_valid_q, redir_valid_d;
    logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
    logic              orphan_q, orphan_d;

    pred_entry_t       head;
    pred_entry_t       push_entry;
    logic              fifo_full, fifo_empty;
    logic              push_c, pop_c, clear_c;
    logic              mispredict_c;
    logic [ADDR_W-1:0] correct_pc_c;

    assign push_entry = '{pc: pred_pc_in, taken: pred_taken_in, target: pred_target_in};

    pred_fifo #(.DEPTH(PRED_DEPTH)) u_fifo (
        .clk_in    (clk_in),
        .rst_N_in  (rst_N_in),
        .push_in   (push_c),
        .pop_in    (pop_c),
        .clear_in  (clear_c),
        .din_in    (push_entry),
        .head_out  (head),
        .full_out  (fifo_full),
        .empty_out (fifo_empty)
    );

    assign pred_ready_out = (state_q == IDLE) && !fifo_full;
    assign mispredict_c   = (res_taken_in != head.taken) ||
                            (res_taken_in && (res_target_in != head.target));
    assign correct_pc_c   = res_taken_in ? res_target_in : head.pc + ADDR_W'(4);

    // Next-state, queue control and registered output values.
    always_comb begin
        state_d       = state_q;
        flush_d       = 1'b0;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        orphan_d      = orphan_q;
        pop_c         = 1'b0;
        clear_c       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (res_valid_in) begin
                    if (fifo_empty) begin
                        orphan_d = 1'b1;
                    end else begin
                        pop_c = 1'b1;
                        if (mispredict_c) begin
                            clear_c    = 1'b1;
                            redir_pc_d = correct_pc_c;
                            flush_d    = 1'b1;
                            state_d    = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                redir_valid_d = 1'b1;
                state_d       = REDIRECT;
            end
            REDIRECT: begin
                if (redirect_ready_in) begin
                    redir_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                redir_valid_d = 1'b0;
                state_d       = IDLE;
            end
        endcase
        push_c = pred_valid_in && pred_ready_out && !clear_c;
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            state_q       <= IDLE;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            orphan_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            orphan_q      <= orphan_d;
        end
    end

    assign flush_out          = flush_q;
    assign redirect_valid_out = redir_valid_q;
    assign redirect_pc_out    = redir_pc_q;
    assign orphan_err_out     = orphan_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] res_cnt_q, res_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    // A pop is an accepted resolution; a clear only happens on mispredict.
    always_comb begin
        res_cnt_d = res_cnt_q + 32'(pop_c);
        mis_cnt_d = mis_cnt_q + 32'(clear_c);
    end

    // Performance counter registers.
    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            res_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            res_cnt_q <= res_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign res_count_out     = res_cnt_q;
    assign mispred_count_out = mis_cnt_q;
`else
    assign res_count_out     = '0;
    assign mispred_count_out = '0;
`endif

endmodule

// File: tb/tb_bru_redirect_ctrl.sv
// Self-checking bench for bru_redirect_ctrl: directed scenarios then random traffic
// against a queue-based behavioural model.
module tb_bru_redirect_ctrl;

    typedef struct {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] target;
    } ent_t;

    logic        clk_in = 1'b0;
    logic        rst_N_in = 1'b0;
    logic        pred_valid_in = 1'b0;
    logic        pred_ready_out;
    logic [63:0] pred_pc_in = '0;
    logic        pred_taken_in = 1'b0;
    logic [63:0] pred_target_in = '0;
    logic        res_valid_in = 1'b0;
    logic        res_taken_in = 1'b0;
    logic [63:0] res_target_in = '0;
    logic        flush_out;
    logic        redirect_valid_out;
    logic        redirect_ready_in = 1'b0;
    logic [63:0] redirect_pc_out;
    logic        orphan_err_out;
    logic [31:0] res_count_out;
    logic [31:0] mispred_count_out;

    int total = 0;
    int bad   = 0;

    ent_t        mq[$];
    bit          m_flush, m_redir, m_orphan;
    logic [63:0] m_pc;
    int unsigned m_rc, m_mc;

    bru_redirect_ctrl dut (
        .clk_in             (clk_in),
        .rst_N_in           (rst_N_in),
        .pred_valid_in      (pred_valid_in),
        .pred_ready_out     (pred_ready_out),
        .pred_pc_in         (pred_pc_in),
        .pred_taken_in      (pred_taken_in),
        .pred_target_in     (pred_target_in),
        .res_valid_in       (res_valid_in),
        .res_taken_in       (res_taken_in),
        .res_target_in      (res_target_in),
        .flush_out          (flush_out),
        .redirect_valid_out (redirect_valid_out),
        .redirect_ready_in  (redirect_ready_in),
        .redirect_pc_out    (redirect_pc_out),
        .orphan_err_out     (orphan_err_out),
        .res_count_out      (res_count_out),
        .mispred_count_out  (mispred_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural model: one clock edge worth of the documented rules.
    task automatic model_step();
        bit   room;
        bit   mis;
        ent_t e;
        if (!rst_N_in) begin
            mq.delete();
            m_flush = 0; m_redir = 0; m_orphan = 0;
            m_pc = '0; m_rc = 0; m_mc = 0;
        end else if (m_flush) begin
            m_flush = 0;
            m_redir = 1;
        end else if (m_redir) begin
            if (redirect_ready_in) m_redir = 0;
        end else begin
            room = (mq.size() < 8);
            mis  = 0;
            if (res_valid_in) begin
                if (mq.size() == 0) begin
                    m_orphan = 1;
                end else begin
                    e = mq.pop_front();
                    m_rc++;
                    mis = (res_taken_in != e.taken) || (res_taken_in && res_target_in != e.target);
                    if (mis) begin
                        m_mc++;
                        m_pc = res_taken_in ? res_target_in : e.pc + 64'd4;
                        mq.delete();
                        m_flush = 1;
                    end
                end
            end
            if (pred_valid_in && room && !mis)
                mq.push_back('{pc: pred_pc_in, taken: pred_taken_in, target: pred_target_in});
        end
    endtask

    task automatic tick();
        logic [31:0] exp_rc, exp_mc;
        model_step();
        @(posedge clk_in);
        #1;
`ifdef BRU_PERF_CNT_EN
        exp_rc = m_rc; exp_mc = m_mc;
`else
        exp_rc = 32'd0; exp_mc = 32'd0;
`endif
        chk("flush", 64'(flush_out), 64'(m_flush));
        chk("redirect_valid", 64'(redirect_valid_out), 64'(m_redir));
        chk("redirect_pc", redirect_pc_out, m_pc);
        chk("pred_ready", 64'(pred_ready_out), 64'(!m_flush && !m_redir && mq.size() < 8));
        chk("orphan", 64'(orphan_err_out), 64'(m_orphan));
        chk("res_count", 64'(res_count_out), 64'(exp_rc));
        chk("mispred_count", 64'(mispred_count_out), 64'(exp_mc));
    endtask

    task automatic set_push(input bit v, input logic [63:0] pc, input bit t, input logic [63:0] tg);
        pred_valid_in = v; pred_pc_in = pc; pred_taken_in = t; pred_target_in = tg;
    endtask

    task automatic set_res(input bit v, input bit t, input logic [63:0] tg);
        res_valid_in = v; res_taken_in = t; res_target_in = tg;
    endtask

    // Drive a resolution that agrees with the model's head entry.
    task automatic res_correct();
        if (mq.size() > 0) set_res(1, mq[0].taken, mq[0].target);
        else set_res(1, 0, '0);
    endtask

    task automatic idle_inputs();
        set_push(0, '0, 0, '0);
        set_res(0, 0, '0);
        redirect_ready_in = 0;
    endtask

    initial begin
        // Reset
        rst_N_in = 0; idle_inputs();
        tick(); tick();
        rst_N_in = 1;
        tick();

        // Correctly predicted taken branch
        set_push(1, 64'h1000, 1, 64'h2000); tick();
        set_push(0, '0, 0, '0); set_res(1, 1, 64'h2000); tick();
        set_res(0, 0, '0); tick();

        // Predicted not-taken, resolved taken; resolutions during flush/redirect ignored
        set_push(1, 64'h1000, 0, 64'h0); tick();
        set_push(0, '0, 0, '0); set_res(1, 1, 64'h3000); tick();
        redirect_ready_in = 1; tick();
        redirect_ready_in = 0; tick(); tick();
        redirect_ready_in = 1; tick();
        set_res(0, 0, '0); redirect_ready_in = 0; tick();

        // Predicted taken, resolved not-taken; redirect held for 3 cycles
        set_push(1, 64'h1000, 1, 64'h2000); tick();
        set_push(0, '0, 0, '0); set_res(1, 0, 64'h0); tick();
        set_res(0, 0, '0); tick();
        tick(); tick(); tick();
        redirect_ready_in = 1; tick();
        redirect_ready_in = 0; tick();

        // Fill the queue, push blocked when full, push+pop across the wrap, drain in order
        for (int i = 0; i < 8; i++) begin
            set_push(1, 64'h4000 + 64'(i * 16), i[0], 64'h5000 + 64'(i * 4));
            tick();
        end
        set_push(1, 64'h4800, 1, 64'h5800); res_correct(); tick();
        set_push(1, 64'h4900, 0, 64'h5900); res_correct(); tick();
        set_push(0, '0, 0, '0);
        for (int i = 0; i < 7; i++) begin
            res_correct(); tick();
        end
        set_res(0, 0, '0); tick();

        // Orphan resolution with empty queue: sticky, no redirect
        set_res(1, 1, 64'h7000); tick();
        set_res(0, 0, '0); tick(); tick();

        // Reset during FLUSH aborts the redirect
        set_push(1, 64'h1100, 0, 64'h0); tick();
        set_push(0, '0, 0, '0); set_res(1, 1, 64'h9000); tick();
        set_res(0, 0, '0); rst_N_in = 0; tick();
        rst_N_in = 1; tick(); tick(); tick();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rst_N_in = ($urandom_range(0, 199) != 0);
            set_push($urandom_range(0, 1) == 1, 64'h1000 + 64'($urandom_range(0, 15) * 4),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) ? 64'h2000 : 64'h3000);
            if ($urandom_range(0, 2) == 0) begin
                if (mq.size() > 0 && $urandom_range(0, 4) != 0) res_correct();
                else set_res(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) ? 64'h2000 : 64'h3000);
            end else begin
                set_res(0, 0, '0);
            end
            redirect_ready_in = $urandom_range(0, 1) == 1;
            tick();
        end

        idle_inputs();
        rst_N_in = 1;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
